// File: rtl/dev_bridge.sv
// dev_bridge: CPU-to-device bridge with a three-state access FSM, address decode and error reporting
// for two word-mapped devices, plus level-sampled interrupt pending bits.
module dev_bridge #(
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
    parameter int unsigned DEV_SPAN  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic        PrWE,
    input  logic        PrRE,
    output logic [31:0] PrRD,
    output logic        PrReady,
    output logic        PrErr,
    output logic        PrBusy,
    output logic [31:0] DEV_Addr,
    output logic [31:0] DEV_WD,
    output logic        DEV0_WE,
    output logic        DEV1_WE,
    input  logic [31:0] DEV0_RD,
    input  logic [31:0] DEV1_RD,
    input  logic        intrp0,
    input  logic        intrp1,
    input  logic [1:0]  IntClr,
    output logic [5:0]  HWInt
);
    localparam logic [1:0]  IDLE   = 2'd0;
    localparam logic [1:0]  ACCESS = 2'd1;
    localparam logic [1:0]  RESP   = 2'd2;
    localparam logic [31:0] SPAN   = 32'(DEV_SPAN);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d, wd_q, wd_d, rd_q, rd_d;
    logic        wr_q, wr_d, err_q, err_d, sel_q, sel_d;
    logic [1:0]  pend_q, pend_d;
    logic        accept, hit0, hit1, req_err;

    always_comb begin
        hit0    = PrAddr >= DEV0_BASE && PrAddr <= DEV0_BASE + SPAN - 32'd1;
        hit1    = PrAddr >= DEV1_BASE && PrAddr <= DEV1_BASE + SPAN - 32'd1;
        req_err = !(hit0 || hit1) || PrAddr[1:0] != 2'b00 || (PrWE && PrRE);
        accept  = state_q == IDLE && (PrWE || PrRE);
        state_d = state_q == ACCESS ? RESP : accept ? ACCESS : IDLE;
        addr_d  = accept ? PrAddr : addr_q;
        wd_d    = accept ? PrWD : wd_q;
        wr_d    = accept ? PrWE : wr_q;
        err_d   = accept ? req_err : err_q;
        sel_d   = accept ? hit1 : sel_q;
        // Valid writes leave the read register untouched; errors always zero it.
        rd_d    = (state_q == ACCESS && (err_q || !wr_q)) ?
                  (err_q ? 32'h0 : sel_q ? DEV1_RD : DEV0_RD) : rd_q;
        // Set wins over clear because the live level is ORed in after masking.
        pend_d  = {intrp1, intrp0} | (pend_q & ~IntClr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
        end
    end

    assign PrRD     = rd_q;
    assign PrReady  = state_q == RESP;
    assign PrErr    = state_q == RESP && err_q;
    assign PrBusy   = state_q != IDLE;
    assign DEV_Addr = addr_q;
    assign DEV_WD   = wd_q;
    assign DEV0_WE  = state_q == ACCESS && wr_q && !err_q && !sel_q;
    assign DEV1_WE  = state_q == ACCESS && wr_q && !err_q && sel_q;
    assign HWInt    = {4'b0000, pend_q};
endmodule

// File: doc/dev_bridge.md
DEV_BRIDGE -- requirements
Module: dev_bridge

Interface
REQ-001 Parameter DEV0_BASE, 32'h0000_7F00, word-aligned base of device 0 window.
REQ-002 Parameter DEV1_BASE, 32'h0000_7F10, word-aligned base of device 1 window.
REQ-003 Parameter DEV_SPAN, 12, window size in bytes (3 words) per device.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; reset=0 forces reset state immediately.
REQ-006 PrAddr  in  32  CPU byte address of request.
REQ-007 PrWD  in  32  CPU write data.
REQ-008 PrWE  in  1  CPU write request, sampled in IDLE only.
REQ-009 PrRE  in  1  CPU read request, sampled in IDLE only.
REQ-010 PrRD  out  32  registered read data to CPU.
REQ-011 PrReady  out  1  one-cycle completion pulse.
REQ-012 PrErr  out  1  one-cycle error pulse, coincident with PrReady.
REQ-013 PrBusy  out  1  high while a transaction is in flight (state != IDLE).
REQ-014 DEV_Addr  out  32  latched device address, shared by both devices.
REQ-015 DEV_WD  out  32  latched device write data, shared.
REQ-016 DEV0_WE / DEV1_WE  out  1 each  per-device write strobes.
REQ-017 DEV0_RD / DEV1_RD  in  32 each  combinational device read data.
REQ-018 intrp0 / intrp1  in  1 each  device interrupt levels.
REQ-019 IntClr  in  2  per-source pending-clear strobes from CPU exception logic.
REQ-020 HWInt  out  6  pending interrupts to CP0; [0]=dev0, [1]=dev1, [5:2]=0.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accepted request, ACCESS->RESP always, RESP->IDLE always.
REQ-022 Request accepted when state=IDLE and (PrWE|PrRE); PrAddr, PrWD, type latched on that edge.
REQ-023 PrWE/PrRE outside IDLE ignored, no queuing; CPU holds until PrBusy=0.
REQ-024 Decode: hit0 = PrAddr in [DEV0_BASE, DEV0_BASE+DEV_SPAN-1]; hit1 likewise for DEV1_BASE.
REQ-025 Error if no hit, PrAddr[1:0]!=0, or PrWE and PrRE both high; error decided at acceptance and latched.
REQ-026 ACCESS, valid write: selected DEVx_WE=1 for exactly that one cycle; other strobe 0.
REQ-027 ACCESS, valid read: PrRD register loads selected DEVx_RD at end of ACCESS.
REQ-028 ACCESS, error: no WE asserted, PrRD loads 32'h0.
REQ-029 RESP: PrReady=1; PrErr=1 if latched error; PrRD held until next read completes.
REQ-030 Latency: request at edge N -> WE high cycle N..N+1 -> PrReady high cycle N+1..N+2; throughput one transaction per 3 cycles.
REQ-031 DEV_Addr/DEV_WD change only at acceptance; stable through ACCESS and RESP.
REQ-032 Pending bit k set on any cycle intrpk=1 (level-sampled); cleared on cycle IntClr[k]=1 and intrpk=0.
REQ-033 Simultaneous set and clear on same bit: set wins.
REQ-034 HWInt[1:0] driven directly from pending register; independent of FSM state.

Reset
REQ-035 reset=0: state=IDLE, PrRD=0, PrReady=0, PrErr=0, PrBusy=0, DEV_Addr=0, DEV_WD=0, DEV0_WE=DEV1_WE=0, pending=0, HWInt=0.
REQ-036 Reset asserted mid-transaction aborts it: no WE pulse, no PrReady after release.
REQ-037 First request accepted on first rising edge with reset=1.

Verification
REQ-038 Write PrAddr=32'h7F04, PrWD=32'hA5A5_0001 -> DEV1_WE=0, DEV0_WE=1 one cycle, DEV_Addr=7F04, DEV_WD=A5A5_0001, PrReady next cycle, PrErr=0.
REQ-039 Read PrAddr=32'h7F18, DEV1_RD=32'h0000_1234 -> no WE, PrRD=0000_1234 with PrReady two cycles after request.
REQ-040 Requests 32'h7F0C, 32'h7F02, and PrWE=PrRE=1 at 7F00 -> each PrReady+PrErr, no WE, PrRD=0.
REQ-041 intrp1 pulsed 1 cycle then IntClr=2'b10 -> HWInt=6'b000010 until clear edge, then 0; IntClr with intrp1 high -> bit stays 1.
REQ-042 reset=0 during ACCESS of a write -> WE drops immediately, all outputs at reset values, no PrReady after release.
REQ-043 PrWE held high through back-to-back writes -> second write accepted only when PrBusy=0, exactly one WE pulse per 3 cycles.
